axis_multi_inject: RTL and testbench

AXIS_MULTI_INJECT -- requirements
Module: axis_multi_inject

---
 rtl/noc_pkg.sv | 36 +++
 rtl/noc_credit_counter.sv | 41 ++++
 rtl/axis_multi_inject.sv | 161 ++++++++++++++++
 tb/tb_axis_multi_inject.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC types and helpers for injection and router ports.
package noc_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int MAX_CH_W     = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } inj_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid searching upward from ptr+1, wrapping at num.
  function automatic rr_pick_t rr_next(
    input logic [MAX_CHANNELS-1:0] valid,
    input logic [MAX_CH_W-1:0]     ptr,
    input int unsigned             num = MAX_CHANNELS
  );
    rr_pick_t            pick;
    logic [MAX_CH_W-1:0] cand;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
      cand = MAX_CH_W'((32'(ptr) + k) % num);
      if (k <= num && !pick.found && valid[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: credit tracker for one router input buffer.
// Saturates at the buffer depth; a return at full is flagged sticky.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter  int FLIT_BUFFER_DEPTH = 8,
  localparam int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic                    inc,
  input  logic                    dec,
  output logic [CREDIT_WIDTH-1:0] cnt,
  output logic                    nonzero,
  output logic                    err
);

  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  // Count update: simultaneous inc/dec cancel, return at full raises err.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      cnt <= FULL;
      err <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt == FULL) err <= 1'b1;
          else             cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/axis_multi_inject.sv
// axis_multi_inject: round-robin wormhole injector from several AXIS
// channels into one credit-controlled router local port.
// Optional statistics (pkt_count, stall_cycles): AXIS_MULTI_INJECT_STATS_EN.
//
// state  | meaning
// IDLE   | no packet open; pick next valid channel round-robin
// LOCKED | packet open on grant; only grant may send until its tail
module axis_multi_inject
  import noc_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 8
) (
  input  logic                                   clk_noc,
  input  logic                                   rst_noc_sync,
  input  logic [NUM_CHANNELS-1:0]                axis_in_tvalid,
  output logic [NUM_CHANNELS-1:0]                axis_in_tready,
  input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_CHANNELS-1:0]                axis_in_tlast,
  input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0] axis_in_tdest,
  output logic [FLIT_WIDTH-1:0]                  data_out,
  output logic [DEST_WIDTH-1:0]                  dest_out,
  output logic                                   is_tail_out,
  output logic                                   send_out,
  input  logic                                   credit_in,
  output logic                                   credit_err
`ifdef AXIS_MULTI_INJECT_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][15:0]          pkt_count,
  output logic [31:0]                            stall_cycles
`endif
);

  localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  inj_state_t              state, state_nxt;
  logic [CH_W-1:0]         grant, grant_nxt;
  logic [CH_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]         sel;
  rr_pick_t                pick;
  logic                    sel_active;
  logic                    ready_ok;
  logic                    hs;
  logic                    sel_last;
  logic [CREDIT_WIDTH-1:0] credit_cnt;
  logic                    credit_nonzero;
  logic                    unused_credit_cnt;

  // Round-robin candidate among valid channels, starting after rr_ptr.
  always_comb begin
    pick = rr_next(MAX_CHANNELS'(axis_in_tvalid), MAX_CH_W'(rr_ptr), NUM_CHANNELS);
  end

  // FSM state register with arbitration pointer and grant.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // FSM next state: a non-tail head locks the channel until its tail.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (hs) begin
          grant_nxt = sel;
          if (sel_last) rr_ptr_nxt = sel;
          else          state_nxt  = LOCKED;
        end
      end
      LOCKED: begin
        if (hs && sel_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: one-hot tready on the serviced channel, gated by credit.
  // Only the registered credit count gates acceptance, so a credit arriving
  // this cycle cannot admit a flit this cycle.
  always_comb begin
    sel        = grant;
    sel_active = 1'b1;
    if (state == IDLE) begin
      sel        = CH_W'(pick.idx);
      sel_active = pick.found;
    end
    ready_ok       = sel_active && credit_nonzero && !rst_noc_sync;
    axis_in_tready = '0;
    if (ready_ok) axis_in_tready[sel] = 1'b1;
    hs       = ready_ok && axis_in_tvalid[sel];
    sel_last = axis_in_tlast[sel];
  end

  // Register the accepted flit toward the router one cycle after handshake.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= hs;
      if (hs) begin
        data_out    <= axis_in_tdata[sel];
        dest_out    <= axis_in_tdest[sel];
        is_tail_out <= sel_last;
      end
    end
  end

  // The credit is consumed at acceptance (the flit is then committed to
  // send_out), so back-to-back accepts can never overrun the buffer.
  noc_credit_counter #(
    .FLIT_BUFFER_DEPTH(FLIT_BUFFER_DEPTH)
  ) u_credit (
    .clk_noc     (clk_noc),
    .rst_noc_sync(rst_noc_sync),
    .inc         (credit_in),
    .dec         (hs),
    .cnt         (credit_cnt),
    .nonzero     (credit_nonzero),
    .err         (credit_err)
  );

  // Full count is kept for observation; gating only needs nonzero.
  assign unused_credit_cnt = ^credit_cnt;

`ifdef AXIS_MULTI_INJECT_STATS_EN
  // Per-channel accepted-tail counters and credit-starvation cycle counter.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      pkt_count    <= '0;
      stall_cycles <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (hs && sel_last && sel == CH_W'(c) && pkt_count[c] != 16'hFFFF)
          pkt_count[c] <= pkt_count[c] + 16'd1;
      end
      if ((|axis_in_tvalid) && !credit_nonzero && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_multi_inject.sv
// tb_axis_multi_inject: table-driven bench for axis_multi_inject plus
// hand sequences for mid-packet reset and credit exhaustion (depth 2).
module tb_axis_multi_inject;
  import noc_pkg::*;

  localparam int NCH   = 4;
  localparam int FW    = 64;
  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int NV    = 29;

  logic clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  logic                   rst_noc_sync;
  logic [NCH-1:0]         tvalid, tready, tlast;
  logic [NCH-1:0][FW-1:0] tdata;
  logic [NCH-1:0][DW-1:0] tdest;
  logic [FW-1:0]          data_out;
  logic [DW-1:0]          dest_out;
  logic                   is_tail_out, send_out, credit_in, credit_err;

  logic [1:0]             e_tvalid, e_tready, e_tlast;
  logic [1:0][FW-1:0]     e_tdata;
  logic [1:0][DW-1:0]     e_tdest;
  logic [FW-1:0]          e_data_out;
  logic [DW-1:0]          e_dest_out;
  logic                   e_is_tail_out, e_send_out, e_credit_in, e_credit_err;

`ifdef AXIS_MULTI_INJECT_STATS_EN
  logic [NCH-1:0][15:0]   pkt_count;
  logic [31:0]            stall_cycles;
  logic [1:0][15:0]       e_pkt_count;
  logic [31:0]            e_stall_cycles;
`endif

  axis_multi_inject #(
    .NUM_CHANNELS(NCH), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tdest(tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_err(credit_err)
`ifdef AXIS_MULTI_INJECT_STATS_EN
    , .pkt_count(pkt_count), .stall_cycles(stall_cycles)
`endif
  );

  axis_multi_inject #(
    .NUM_CHANNELS(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(2)
  ) dut_ex (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
    .axis_in_tvalid(e_tvalid), .axis_in_tready(e_tready), .axis_in_tdata(e_tdata),
    .axis_in_tlast(e_tlast), .axis_in_tdest(e_tdest),
    .data_out(e_data_out), .dest_out(e_dest_out), .is_tail_out(e_is_tail_out),
    .send_out(e_send_out), .credit_in(e_credit_in), .credit_err(e_credit_err)
`ifdef AXIS_MULTI_INJECT_STATS_EN
    , .pkt_count(e_pkt_count), .stall_cycles(e_stall_cycles)
`endif
  );

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       cr;
    logic [3:0] rdy;
    logic       send;
    logic [1:0] ch;
    logic       tail;
    logic [3:0] cnt;
    logic       err;
    logic       st;
  } vec_t;

  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;
  int   sent;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic cr,
                              input logic [3:0] rdy, input logic send, input logic [1:0] ch,
                              input logic tail, input logic [3:0] cnt, input logic err,
                              input logic st);
    vec_t r;
    r.v = v; r.l = l; r.cr = cr; r.rdy = rdy; r.send = send; r.ch = ch;
    r.tail = tail; r.cnt = cnt; r.err = err; r.st = st;
    return r;
  endfunction

  function automatic logic [63:0] mkdata(input int c, input int i);
    return {40'h0, 8'hDA, 8'(c), 8'(i)};
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic cr, input int i);
    tvalid    = v;
    tlast     = l;
    credit_in = cr;
    for (int c = 0; c < NCH; c++) begin
      tdata[c] = mkdata(c, i);
      tdest[c] = 6'h20 | 6'(c);
    end
  endtask

  initial begin
    rst_noc_sync = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 0);
    e_tvalid = '0; e_tlast = '0; e_credit_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      e_tdata[c] = mkdata(c, 99);
      e_tdest[c] = 6'h30 | 6'(c);
    end

    //              v        l        cr    rdy      s  ch  t  cnt  e  st
    vecs[0]  = mk(4'b1111, 4'b1111, 1'b0, 4'b0001, 1, 0, 1, 4'd7, 0, 0);
    vecs[1]  = mk(4'b1111, 4'b1111, 1'b0, 4'b0010, 1, 1, 1, 4'd6, 0, 0);
    vecs[2]  = mk(4'b1111, 4'b1111, 1'b0, 4'b0100, 1, 2, 1, 4'd5, 0, 0);
    vecs[3]  = mk(4'b1111, 4'b1111, 1'b0, 4'b1000, 1, 3, 1, 4'd4, 0, 0);
    vecs[4]  = mk(4'b1111, 4'b1111, 1'b0, 4'b0001, 1, 0, 1, 4'd3, 0, 0);
    vecs[5]  = mk(4'b0010, 4'b0010, 1'b1, 4'b0010, 1, 1, 1, 4'd3, 0, 0);
    vecs[6]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd4, 0, 0);
    vecs[7]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd5, 0, 0);
    vecs[8]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd6, 0, 0);
    vecs[9]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd7, 0, 0);
    vecs[10] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd8, 0, 0);
    vecs[11] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 4'd8, 1, 0);
    vecs[12] = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 1, 0, 0, 4'd7, 1, 1);
    vecs[13] = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 1, 0, 0, 4'd6, 1, 1);
    vecs[14] = mk(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, 1, 4'd5, 1, 0);
    vecs[15] = mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 1, 1, 0, 4'd5, 1, 1);
    vecs[16] = mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 1, 1, 0, 4'd5, 1, 1);
    vecs[17] = mk(4'b0100, 4'b0000, 1'b0, 4'b0010, 0, 0, 0, 4'd5, 1, 1);
    vecs[18] = mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 1, 1, 0, 4'd5, 1, 1);
    vecs[19] = mk(4'b0110, 4'b0010, 1'b1, 4'b0010, 1, 1, 1, 4'd5, 1, 0);
    vecs[20] = mk(4'b0100, 4'b0100, 1'b0, 4'b0100, 1, 2, 1, 4'd4, 1, 0);
    vecs[21] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 4'd3, 1, 0);
    vecs[22] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 4'd2, 1, 0);
    vecs[23] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 4'd1, 1, 0);
    vecs[24] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 4'd0, 1, 0);
    vecs[25] = mk(4'b1000, 4'b1000, 1'b0, 4'b0000, 0, 0, 0, 4'd0, 1, 0);
    vecs[26] = mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 0, 0, 0, 4'd1, 1, 0);
    vecs[27] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 4'd0, 1, 0);
    vecs[28] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 4'd0, 1, 0);

    // Reset state.
    repeat (2) @(posedge clk_noc);
    #1;
    chk("rst_send", 0, 64'(send_out), 64'd0);
    chk("rst_data", 0, data_out, 64'd0);
    chk("rst_dest", 0, 64'(dest_out), 64'd0);
    chk("rst_tail", 0, 64'(is_tail_out), 64'd0);
    chk("rst_tready", 0, 64'(tready), 64'd0);
    chk("rst_err", 0, 64'(credit_err), 64'd0);
    chk("rst_cnt", 0, 64'(dut.credit_cnt), 64'd8);
    chk("rst_state", 0, 64'(dut.state), 64'(IDLE));
    @(negedge clk_noc);
    rst_noc_sync = 1'b0;

    // Table: round-robin, simultaneous credit, overflow, 3-flit packet,
    // atomicity with dropped valid, exhaustion and credit timing.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_noc);
      drive(vecs[i].v, vecs[i].l, vecs[i].cr, i);
      #1;
      chk("tready", i, 64'(tready), 64'(vecs[i].rdy));
      @(posedge clk_noc);
      #1;
      chk("send_out", i, 64'(send_out), 64'(vecs[i].send));
      chk("credit_cnt", i, 64'(dut.credit_cnt), 64'(vecs[i].cnt));
      chk("credit_err", i, 64'(credit_err), 64'(vecs[i].err));
      chk("state", i, 64'(dut.state), 64'(vecs[i].st));
      if (vecs[i].send) begin
        chk("data_out", i, data_out, mkdata(int'(vecs[i].ch), i));
        chk("dest_out", i, 64'(dest_out), 64'(6'h20 | 6'(vecs[i].ch)));
        chk("is_tail_out", i, 64'(is_tail_out), 64'(vecs[i].tail));
      end
    end

`ifdef AXIS_MULTI_INJECT_STATS_EN
    chk("pkt_count0", 0, 64'(pkt_count[0]), 64'd3);
    chk("pkt_count1", 1, 64'(pkt_count[1]), 64'd3);
    chk("pkt_count2", 2, 64'(pkt_count[2]), 64'd2);
    chk("pkt_count3", 3, 64'(pkt_count[3]), 64'd6);
    chk("stall_cycles", 0, 64'(stall_cycles), 64'd2);
`endif

    // Refill credits, then reset in the middle of a 4-flit packet.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_noc);
      drive(4'b0, 4'b0, 1'b1, 100 + i);
    end
    @(negedge clk_noc);
    drive(4'b0, 4'b0, 1'b0, 108);
    #1;
    chk("refill_cnt", 0, 64'(dut.credit_cnt), 64'd8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_noc);
      drive(4'b0001, 4'b0000, 1'b0, 110 + i);
      @(posedge clk_noc);
      #1;
      chk("mid_send", i, 64'(send_out), 64'd1);
      chk("mid_data", i, data_out, mkdata(0, 110 + i));
    end
    chk("mid_locked", 0, 64'(dut.state), 64'(LOCKED));
    @(negedge clk_noc);
    rst_noc_sync = 1'b1;
    drive(4'b0001, 4'b0000, 1'b0, 112);
    #1;
    chk("midrst_tready", 0, 64'(tready), 64'd0);
    @(posedge clk_noc);
    #1;
    chk("midrst_send", 0, 64'(send_out), 64'd0);
    chk("midrst_state", 0, 64'(dut.state), 64'(IDLE));
    chk("midrst_cnt", 0, 64'(dut.credit_cnt), 64'd8);
    chk("midrst_err", 0, 64'(credit_err), 64'd0);
    chk("midrst_data", 0, data_out, 64'd0);
    chk("midrst_tail", 0, 64'(is_tail_out), 64'd0);
`ifdef AXIS_MULTI_INJECT_STATS_EN
    chk("midrst_pkt", 0, 64'(pkt_count), 64'd0);
    chk("midrst_stall", 0, 64'(stall_cycles), 64'd0);
`endif
    @(negedge clk_noc);
    rst_noc_sync = 1'b0;
    drive(4'b0001, 4'b0001, 1'b0, 113);
    #1;
    chk("post_tready", 0, 64'(tready), 64'b0001);
    @(posedge clk_noc);
    #1;
    chk("post_send", 0, 64'(send_out), 64'd1);
    chk("post_tail", 0, 64'(is_tail_out), 64'd1);
    chk("post_cnt", 0, 64'(dut.credit_cnt), 64'd7);
    @(negedge clk_noc);
    drive(4'b0, 4'b0, 1'b0, 114);

    // Credit exhaustion on the depth-2 instance: 5 offered, 2 sent.
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_noc);
      e_tvalid = 2'b01; e_tlast = 2'b01; e_credit_in = 1'b0;
      @(posedge clk_noc);
      #1;
      if (e_send_out) sent++;
    end
    chk("exh_sent", 0, 64'(sent), 64'd2);
    @(negedge clk_noc);
    #1;
    chk("exh_tready", 0, 64'(e_tready), 64'd0);
    chk("exh_cnt", 0, 64'(dut_ex.credit_cnt), 64'd0);
    e_credit_in = 1'b1;
    @(posedge clk_noc);
    #1;
    chk("exh_pulse_send", 0, 64'(e_send_out), 64'd0);
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_noc);
      e_credit_in = 1'b0;
      @(posedge clk_noc);
      #1;
      if (e_send_out) sent++;
    end
    chk("exh_after_pulse", 0, 64'(sent), 64'd1);
    chk("exh_err", 0, 64'(e_credit_err), 64'd0);
    @(negedge clk_noc);
    e_tvalid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
